// File: rtl/spu_dma_pkg.sv
// Shared types and constants for the local-store DMA engine.
package spu_dma_pkg;

    localparam int   QW_BYTES = 16;
    localparam logic DIR_GET  = 1'b0;
    localparam logic DIR_PUT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        GET_REQ,
        GET_WAIT,
        GET_WR,
        PUT_RD,
        PUT_CAP,
        PUT_SEND,
        DONE
    } dma_state_t;

endpackage

// File: rtl/dma_addr_gen.sv
// Local-store / external address and quadword count registers.
module dma_addr_gen
    import spu_dma_pkg::*;
#(
    parameter int LS_AW = 11,
    parameter int EA_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [LS_AW-1:0] load_lsa,
    input  logic [EA_W-1:0]  load_ea,
    input  logic [7:0]       load_count,
    output logic [LS_AW-1:0] lsa,
    output logic [EA_W-1:0]  ea,
    output logic             last
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            lsa   <= '0;
            ea    <= '0;
            count <= '0;
        end else if (load) begin
            lsa   <= load_lsa;
            ea    <= load_ea;
            count <= load_count;
        end else if (advance) begin
            // both address spaces wrap naturally at their widths
            lsa   <= lsa + 1'b1;
            ea    <= ea + EA_W'(QW_BYTES);
            count <= count - 8'd1;
        end
    end

    assign last = (count == 8'd1);

endmodule

// File: rtl/ls_dma_engine.sv
// Quadword DMA between the local store and an external request port.
module ls_dma_engine
    import spu_dma_pkg::*;
#(
    parameter int LS_AW = 11,
    parameter int EA_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [LS_AW-1:0] cmd_lsa,
    input  logic [EA_W-1:0]  cmd_ea,
    input  logic [7:0]       cmd_size,
    input  logic [4:0]       cmd_tag,
    output logic             ls_req,
    output logic             ls_we,
    output logic [LS_AW-1:0] ls_addr,
    output logic [127:0]     ls_wdata,
    input  logic [127:0]     ls_rdata,
    output logic             ext_req_valid,
    output logic             ext_req_we,
    output logic [EA_W-1:0]  ext_addr,
    output logic [127:0]     ext_wdata,
    input  logic             ext_req_ready,
    input  logic             ext_rsp_valid,
    input  logic [127:0]     ext_rsp_data,
    output logic             busy,
    output logic             done,
    output logic [4:0]       done_tag
);

    dma_state_t       state;
    dma_state_t       state_nxt;
    logic [127:0]     data_q;
    logic [4:0]       tag_q;
    logic             dir_q;
    logic             load;
    logic             advance;
    logic [LS_AW-1:0] lsa;
    logic [EA_W-1:0]  ea;
    logic             last;
    dma_state_t       repeat_st;

    dma_addr_gen #(
        .LS_AW (LS_AW),
        .EA_W  (EA_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .advance    (advance),
        .load_lsa   (cmd_lsa),
        .load_ea    (cmd_ea),
        .load_count (cmd_size),
        .lsa        (lsa),
        .ea         (ea),
        .last       (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            tag_q  <= '0;
            dir_q  <= DIR_GET;
        end else begin
            if (load) begin
                tag_q <= cmd_tag;
                dir_q <= cmd_dir;
            end
            if (state == GET_WAIT && ext_rsp_valid) begin
                data_q <= ext_rsp_data;
            end
            if (state == PUT_CAP) begin
                data_q <= ls_rdata;
            end
        end
    end

    assign repeat_st = (dir_q == DIR_PUT) ? PUT_RD : GET_REQ;

    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        load          = 1'b0;
        advance       = 1'b0;
        ls_req        = 1'b0;
        ls_we         = 1'b0;
        ls_addr       = '0;
        ls_wdata      = '0;
        ext_req_valid = 1'b0;
        ext_req_we    = 1'b0;
        ext_addr      = '0;
        ext_wdata     = '0;
        done          = 1'b0;
        done_tag      = '0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load = 1'b1;
                    if (cmd_size == 8'd0) begin
                        state_nxt = DONE;
                    end else if (cmd_dir == DIR_PUT) begin
                        state_nxt = PUT_RD;
                    end else begin
                        state_nxt = GET_REQ;
                    end
                end
            end
            GET_REQ: begin
                ext_req_valid = 1'b1;
                ext_addr      = ea;
                if (ext_req_ready) begin
                    state_nxt = GET_WAIT;
                end
            end
            GET_WAIT: begin
                if (ext_rsp_valid) begin
                    state_nxt = GET_WR;
                end
            end
            GET_WR: begin
                ls_req    = 1'b1;
                ls_we     = 1'b1;
                ls_addr   = lsa;
                ls_wdata  = data_q;
                advance   = 1'b1;
                state_nxt = last ? DONE : repeat_st;
            end
            PUT_RD: begin
                ls_req    = 1'b1;
                ls_addr   = lsa;
                state_nxt = PUT_CAP;
            end
            PUT_CAP: begin
                state_nxt = PUT_SEND;
            end
            PUT_SEND: begin
                ext_req_valid = 1'b1;
                ext_req_we    = 1'b1;
                ext_addr      = ea;
                ext_wdata     = data_q;
                if (ext_req_ready) begin
                    advance   = 1'b1;
                    state_nxt = last ? DONE : repeat_st;
                end
            end
            DONE: begin
                done      = 1'b1;
                done_tag  = tag_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
